simple_fifo_lvl: RTL and testbench

Single-clock synchronous FIFO, successor to the basic FIFO used across the fsa datapath.
- Adds runtime-programmable almost-full/almost-empty thresholds, a live occupancy count and sticky overflow/underflow error flags.
- Read mode is selectable by parameter: standard (registered read) or first-word-fall-through (FWFT).
- Used between stream stages where software tunes back-pressure thresholds.

---
 rtl/simple_fifo_lvl.sv | 151 +++++++++++++++
 tb/tb_simple_fifo_lvl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_fifo_lvl.sv
// simple_fifo_lvl: single-clock FIFO with live occupancy, runtime almost-full/almost-empty
// thresholds and sticky overflow/underflow flags. FWFT selects the read style:
//   0 = registered read, rd_data valid the cycle after an accepted pop
//   1 = first-word-fall-through, rd_data already holds the head whenever empty == 0
// Optional build macro SIMPLE_FIFO_LVL_PEAK_EN adds a registered high-water mark (peak_level).
module simple_fifo_lvl #(
    parameter int DEPTH_WIDTH = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int FWFT        = 0,
    // Clamped widths so degenerate parameter values still build a 2-entry, 1-bit FIFO
    localparam int AW = (DEPTH_WIDTH < 1) ? 1 : DEPTH_WIDTH,
    localparam int DW = (DATA_WIDTH < 1) ? 1 : DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_en,
    output logic [DW-1:0] rd_data,
    input  logic          rd_en,
    input  logic [AW:0]   af_th,
    input  logic [AW:0]   ae_th,
    input  logic          clr_err,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow
`ifdef SIMPLE_FIFO_LVL_PEAK_EN
    ,
    output logic [AW:0]   peak_level
`endif
);

    localparam int unsigned  DEPTH    = 1 << AW;
    localparam logic [AW:0]  LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]  LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // Storage; contents are never reset, only pointers and flags are
    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr, wr_ptr_d;
    logic [AW-1:0] rd_ptr, rd_ptr_d;
    logic [AW:0]   level_d;
    logic          we;
    logic          re;
    logic          overflow_d;
    logic          underflow_d;

    // The MSB of level is set only at level == DEPTH, so it is the full flag
    assign full = level[AW];

    // Accept decisions and next-state values, all from registered flags
    always_comb begin
        we          = wr_en & ~full;
        re          = rd_en & ~empty;
        wr_ptr_d    = we ? (wr_ptr + PTR_ONE) : wr_ptr;
        rd_ptr_d    = re ? (rd_ptr + PTR_ONE) : rd_ptr;
        level_d     = level;
        unique case ({we, re})
            2'b10:   level_d = level + LVL_ONE;
            2'b01:   level_d = level - LVL_ONE;
            default: level_d = level;
        endcase
        // A fresh error event wins over clr_err in the same cycle
        overflow_d  = (wr_en & full) | (overflow & ~clr_err);
        underflow_d = (rd_en & empty) | (underflow & ~clr_err);
    end

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and all status flags, registered from the next level
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_d;
            rd_ptr       <= rd_ptr_d;
            level        <= level_d;
            empty        <= (level_d == '0);
            almost_full  <= (level_d >= af_th);
            almost_empty <= (level_d <= ae_th);
            overflow     <= overflow_d;
            underflow    <= underflow_d;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Word that will sit at the head after this cycle; when the head slot is the one
        // being written right now, forward wr_data so a write to an empty FIFO shows next cycle
        logic [DW-1:0] head_d;

        // Select the next head word (write-to-read bypass or storage)
        always_comb begin
            head_d = mem[rd_ptr_d];
            if (we && (rd_ptr_d == wr_ptr)) begin
                head_d = wr_data;
            end
        end

        // Output register tracks the head every cycle; its validity is ~empty, which reset clears
        always_ff @(posedge clk) begin
            rd_data <= head_d;
        end
    end else begin : g_std
        // Registered read: load the popped word, hold until the next accepted pop
        always_ff @(posedge clk) begin
            if (re) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end

`ifdef SIMPLE_FIFO_LVL_PEAK_EN
    logic [AW:0] peak_d;

    // High-water mark; clr_err restarts it from the current occupancy
    always_comb begin
        peak_d = peak_level;
        if (clr_err) begin
            peak_d = level_d;
        end else if (level_d > peak_level) begin
            peak_d = level_d;
        end
    end

    // Peak register
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_level <= '0;
        end else begin
            peak_level <= peak_d;
        end
    end
`endif

endmodule

// File: tb/tb_simple_fifo_lvl.sv
// Bench for simple_fifo_lvl: a standard and an FWFT instance (DEPTH=4) share one stimulus
// stream. Expected read words are queued at write time; per-instance monitors pop and compare
// whenever the instance presents a word. Flags and level are compared against directed values.
module tb_simple_fifo_lvl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       rd_en;
    logic [2:0] af_th;
    logic [2:0] ae_th;
    logic       clr_err;

    logic [7:0] s_rd_data, f_rd_data;
    logic [2:0] s_level, f_level;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
`ifdef SIMPLE_FIFO_LVL_PEAK_EN
    logic [2:0] s_peak, f_peak;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] q_s[$];
    logic [7:0] q_f[$];

    always #5 clk = ~clk;

    simple_fifo_lvl #(.DEPTH_WIDTH(2), .DATA_WIDTH(8), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .rd_data(s_rd_data),
        .rd_en(rd_en), .af_th(af_th), .ae_th(ae_th), .clr_err(clr_err), .level(s_level),
        .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .overflow(s_ovf), .underflow(s_udf)
`ifdef SIMPLE_FIFO_LVL_PEAK_EN
        , .peak_level(s_peak)
`endif
    );

    simple_fifo_lvl #(.DEPTH_WIDTH(2), .DATA_WIDTH(8), .FWFT(1)) u_fw (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .rd_data(f_rd_data),
        .rd_en(rd_en), .af_th(af_th), .ae_th(ae_th), .clr_err(clr_err), .level(f_level),
        .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .overflow(f_ovf), .underflow(f_udf)
`ifdef SIMPLE_FIFO_LVL_PEAK_EN
        , .peak_level(f_peak)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Status vector {level, empty, full, almost_empty, almost_full, overflow, underflow}
    task automatic chk_st(input string name, input logic [2:0] lvl, input logic e,
                          input logic f, input logic ae, input logic af, input logic ov,
                          input logic un);
        logic [8:0] exp;
        exp = {lvl, e, f, ae, af, ov, un};
        chk({name, "_std"}, {23'd0, s_level, s_empty, s_full, s_ae, s_af, s_ovf, s_udf},
            {23'd0, exp});
        chk({name, "_fwft"}, {23'd0, f_level, f_empty, f_full, f_ae, f_af, f_ovf, f_udf},
            {23'd0, exp});
    endtask

    task automatic exp_push(input logic [7:0] d);
        q_s.push_back(d);
        q_f.push_back(d);
    endtask

    // One clock of stimulus; results are sampled 1 time unit after the edge
    task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr_err = c;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    // Standard-mode monitor: a pop accepted at an edge presents its word just after that edge
    initial begin
        logic fire;
        logic [7:0] e;
        forever begin
            @(posedge clk);
            fire = rd_en && !s_empty && !rst;
            #1;
            if (fire) begin
                if (q_s.size() == 0) begin
                    chk("std_rd_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q_s.pop_front();
                    chk("std_rd", {24'd0, s_rd_data}, {24'd0, e});
                end
            end
        end
    end

    // FWFT monitor: the head word is on rd_data before the popping edge
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            if (rd_en && !f_empty && !rst) begin
                if (q_f.size() == 0) begin
                    chk("fwft_rd_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q_f.pop_front();
                    chk("fwft_rd", {24'd0, f_rd_data}, {24'd0, e});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] l;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
        af_th = 3'd3; ae_th = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_st("reset", 3'd0, 1, 0, 1, 0, 0, 0);

        // Fill 1..4: almost_empty falls entering 2, almost_full rises entering 3
        for (int i = 1; i <= 4; i++) begin
            exp_push(8'(i));
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            l = 3'(i);
            chk_st("fill", l, 1'b0, (i == 4), (i <= 1), (i >= 3), 1'b0, 1'b0);
            if (i == 1) chk("fwft_bypass", {24'd0, f_rd_data}, 32'd1);
        end
        drive(1'b1, 8'd5, 1'b0, 1'b0);
        chk_st("write_full", 3'd4, 0, 1, 0, 1, 1, 0);
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        chk_st("clr_ovf", 3'd4, 0, 1, 0, 1, 0, 0);
        for (int i = 3; i >= 0; i--) begin
            drive(1'b0, 8'd0, 1'b1, 1'b0);
            l = 3'(i);
            chk_st("drain", l, (i == 0), 1'b0, (i <= 1), (i >= 3), 1'b0, 1'b0);
        end

        // Simultaneous read/write on empty, then on full
        exp_push(8'h11);
        drive(1'b1, 8'h11, 1'b1, 1'b0);
        chk_st("sim_empty", 3'd1, 0, 0, 1, 0, 0, 1);
        for (int j = 2; j <= 4; j++) begin
            exp_push(8'(8'h10 + j));
            drive(1'b1, 8'(8'h10 + j), 1'b0, 1'b0);
        end
        drive(1'b1, 8'h99, 1'b1, 1'b0);
        chk_st("sim_full", 3'd3, 0, 0, 0, 1, 1, 1);
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        chk_st("clr_both", 3'd3, 0, 0, 0, 1, 0, 0);

        // Threshold changes while idle at level 3
        af_th = 3'd4;
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        chk_st("af_th4", 3'd3, 0, 0, 0, 0, 0, 0);
        af_th = 3'd0;
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        chk_st("af_th0", 3'd3, 0, 0, 0, 1, 0, 0);
        af_th = 3'd3;
        ae_th = 3'd4;
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        chk_st("ae_th4", 3'd3, 0, 0, 1, 1, 0, 0);
        ae_th = 3'd1;
        repeat (3) drive(1'b0, 8'd0, 1'b1, 1'b0);
        chk_st("drain2", 3'd0, 1, 0, 1, 0, 0, 0);

        // FWFT single word
        exp_push(8'hA5);
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("fwft_a5_data", {24'd0, f_rd_data}, 32'hA5);
        chk("fwft_a5_empty", {31'd0, f_empty}, 32'd0);
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        chk_st("a5_pop", 3'd0, 1, 0, 1, 0, 0, 0);

        // Wrap-around: 20 write/read pairs
        for (int i = 0; i < 20; i++) begin
            exp_push(8'(8'h30 + i));
            drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
            chk_st("wrap_w", 3'd1, 0, 0, 1, 0, 0, 0);
            drive(1'b0, 8'd0, 1'b1, 1'b0);
            chk_st("wrap_r", 3'd0, 1, 0, 1, 0, 0, 0);
        end

        // Underflow stays set when clr_err meets a new read-while-empty
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        chk_st("udf", 3'd0, 1, 0, 1, 0, 0, 1);
        drive(1'b0, 8'd0, 1'b1, 1'b1);
        chk_st("udf_clr_same", 3'd0, 1, 0, 1, 0, 0, 1);

        // Reset mid-traffic at level 3 with wr_en high
        for (int i = 1; i <= 3; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        chk_st("pre_rst", 3'd3, 0, 0, 0, 1, 0, 1);
        q_s.delete();
        q_f.delete();
        rst = 1'b1;
        drive(1'b1, 8'h44, 1'b0, 1'b0);
        rst = 1'b0;
        chk_st("rst_mid", 3'd0, 1, 0, 1, 0, 0, 0);
`ifdef SIMPLE_FIFO_LVL_PEAK_EN
        chk("peak_rst_std", {29'd0, s_peak}, 32'd0);
        chk("peak_rst_fwft", {29'd0, f_peak}, 32'd0);
`endif
        for (int i = 1; i <= 4; i++) begin
            exp_push(8'(8'h50 + i));
            drive(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        end
        chk_st("refill", 3'd4, 0, 1, 0, 1, 0, 0);
`ifdef SIMPLE_FIFO_LVL_PEAK_EN
        chk("peak_refill_std", {29'd0, s_peak}, 32'd4);
        chk("peak_refill_fwft", {29'd0, f_peak}, 32'd4);
`endif
        repeat (4) drive(1'b0, 8'd0, 1'b1, 1'b0);
        chk_st("final_drain", 3'd0, 1, 0, 1, 0, 0, 0);
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        chk("q_std_left", q_s.size(), 32'd0);
        chk("q_fwft_left", q_f.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
